// File: rtl/rom_boot_loader.sv
// Boot sequencer: copies the instruction ROM image into instruction RAM while holding the core.
// Optional macro BOOT_CHECKSUM_EN adds a running checksum gate on cpu_hold release.
`timescale 1ns/1ps
module rom_boot_loader #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int WORDS      = 428,
   parameter int LOAD_BASE  = 0,
   parameter int AUTO_START = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic              ram_ready,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   input  logic [DATA_W-1:0] expected_sum,
   output logic              csum_ok
);

   typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS - 1);
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(LOAD_BASE);
   localparam bit                AUTO = (AUTO_START != 0);

   state_t            state;
   logic [ADDR_W-1:0] idx;
   logic              go;
   logic              accept;
   logic              csum_pass;

   // IDLE is only reachable through reset, so AUTO_START can launch from it directly.
   assign go     = ((state == IDLE) && (start || AUTO)) || ((state == DONE) && start);
   assign accept = (state == WRITE) && ram_ready;

`ifdef BOOT_CHECKSUM_EN
   logic [DATA_W-1:0] sum;

   // Compare against the sum including the word accepted on the DONE-entry edge.
   assign csum_pass = ((sum + ram_wdata) == expected_sum);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      sum <= '0;
      else if (go)     sum <= '0;
      else if (accept) sum <= sum + ram_wdata;
   end
`else
   logic unused_expected_sum;
   assign unused_expected_sum = ^expected_sum;
   assign csum_pass = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         rom_addr  <= '0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         cpu_hold  <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         csum_ok   <= 1'b0;
      end else if (go) begin
         state    <= FETCH;
         idx      <= '0;
         rom_addr <= '0;
         busy     <= 1'b1;
         done     <= 1'b0;
         cpu_hold <= 1'b1;
         csum_ok  <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               ram_wdata <= rom_data;
               ram_addr  <= BASE + idx;
               ram_we    <= 1'b1;
               state     <= WRITE;
            end
            WRITE: begin
               if (ram_ready) begin
                  ram_we <= 1'b0;
                  if (idx == LAST) begin
                     state    <= DONE;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     csum_ok  <= csum_pass;
                     cpu_hold <= ~csum_pass;
                  end else begin
                     idx      <= idx + 1'b1;
                     rom_addr <= idx + 1'b1;
                     state    <= FETCH;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_boot_loader.sv
// Directed bench for rom_boot_loader: 4-word image, stall, wrap, reset abort, restart, checksum.
`timescale 1ns/1ps
module tb_rom_boot_loader;
   localparam int AW = 10;
   localparam int DW = 32;

   logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, ram_ready = 1'b1;
   logic [DW-1:0] expected_sum = 32'h4B00_0078;   // 0x4B00006F + 2 + 3 + 4
   logic [DW-1:0] rom0 = 32'h4B00_006F;
   logic [AW-1:0] rom_addr, ram_addr, rom_addr2, ram_addr2;
   logic [DW-1:0] rom_data, ram_wdata, rom_data2, unused_wdata2;
   logic          ram_we, cpu_hold, busy, done, csum_ok, ram_we2;
   logic          unused_hold2, unused_busy2, unused_done2, unused_csum2;

   int pass_cnt = 0, total = 0, cyc = 0, e0 = 0, n = 0;
   int            wa[$];
   logic [DW-1:0] wd[$];
   int            wc[$];
   int            a2[$];

   always #5 clk = ~clk;

   assign rom_data  = (rom_addr == 0) ? rom0 : (rom_addr < 4) ? {22'b0, rom_addr} + 32'd1 : 32'hDEAD_BEEF;
   assign rom_data2 = {22'b0, rom_addr2};

   rom_boot_loader #(.ADDR_W(AW), .DATA_W(DW), .WORDS(4), .LOAD_BASE(0), .AUTO_START(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_ready(ram_ready),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .expected_sum(expected_sum), .csum_ok(csum_ok));

   rom_boot_loader #(.ADDR_W(AW), .DATA_W(DW), .WORDS(4), .LOAD_BASE(1022), .AUTO_START(1)) u_wrap (
      .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr2), .rom_data(rom_data2),
      .ram_we(ram_we2), .ram_addr(ram_addr2), .ram_wdata(unused_wdata2), .ram_ready(1'b1),
      .cpu_hold(unused_hold2), .busy(unused_busy2), .done(unused_done2), .expected_sum(32'd0),
      .csum_ok(unused_csum2));

   // RAM model: log every accepted write with the edge count it happened on.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ram_we && ram_ready) begin
         wa.push_back(int'(ram_addr));
         wd.push_back(ram_wdata);
         wc.push_back(cyc + 1);
      end
      if (ram_we2) a2.push_back(int'(ram_addr2));
   end

   task automatic clear_log();
      wa.delete(); wd.delete(); wc.delete(); a2.delete();
   endtask

   // Releases reset; the following rising edge is the FETCH entry edge.
   task automatic release_reset();
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1; e0 = cyc;
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0; e0 = cyc;
   endtask

   task automatic wait_done(output int cycles);
      cycles = 0;
      while (done !== 1'b1 && cycles < 60) begin
         @(posedge clk); #1; cycles = cyc - e0;
      end
   endtask

   task automatic test_reset();
      #12;
      if ({rom_addr, ram_we, ram_addr, ram_wdata} !== 53'd0) $display("FAIL rst_data: got %0h want 0", {rom_addr, ram_we, ram_addr, ram_wdata}); else pass_cnt++;
      total++;
      if ({cpu_hold, busy, done, csum_ok} !== 4'b1000) $display("FAIL rst_flags: got %b want 1000", {cpu_hold, busy, done, csum_ok}); else pass_cnt++;
      total++;
   endtask

   task automatic test_auto_copy();
      logic [DW-1:0] exp_d[4];
      exp_d = '{32'h4B00_006F, 32'd2, 32'd3, 32'd4};
      clear_log();
      release_reset();
      if ({cpu_hold, busy, done} !== 3'b110) $display("FAIL auto_entry: got %b want 110", {cpu_hold, busy, done}); else pass_cnt++;
      total++;
      wait_done(n);
      if (n !== 8) $display("FAIL auto_latency: got %0d want 8", n); else pass_cnt++;
      total++;
      if ({cpu_hold, busy, csum_ok} !== 3'b001) $display("FAIL auto_done_flags: got %b want 001", {cpu_hold, busy, csum_ok}); else pass_cnt++;
      total++;
      if (wa.size() !== 4) $display("FAIL auto_wr_count: got %0d want 4", wa.size()); else pass_cnt++;
      total++;
      for (int k = 0; k < 4 && k < wa.size(); k++) begin
         if (wa[k] !== k || wd[k] !== exp_d[k] || wc[k] !== e0 + 2*k + 2)
            $display("FAIL auto_wr%0d: got a=%0d d=%0h c=%0d want a=%0d d=%0h c=%0d", k, wa[k], wd[k], wc[k] - e0, k, exp_d[k], 2*k + 2);
         else pass_cnt++;
         total++;
      end
      if (a2.size() !== 4 || a2[0] !== 1022 || a2[1] !== 1023 || a2[2] !== 0 || a2[3] !== 1)
         $display("FAIL wrap_addr: got n=%0d %0d %0d %0d %0d want 4 1022 1023 0 1", a2.size(), a2[0], a2[1], a2[2], a2[3]);
      else pass_cnt++;
      total++;
   endtask

   task automatic test_stall();
      rst_n = 1'b0;
      @(posedge clk); #1;
      clear_log();
      release_reset();
      repeat (5) begin @(posedge clk); #1; end
      for (int i = 0; i < 4; i++) begin
         if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 10'd2, 32'd3})
            $display("FAIL stall_hold%0d: got we=%b a=%0d d=%0h want we=1 a=2 d=3", i, ram_we, ram_addr, ram_wdata);
         else pass_cnt++;
         total++;
         if (i == 0) ram_ready = 1'b0;
         if (i == 3) ram_ready = 1'b1;
         if (i < 3) begin @(posedge clk); #1; end
      end
      wait_done(n);
      if (n !== 11) $display("FAIL stall_latency: got %0d want 11", n); else pass_cnt++;
      total++;
      if (wa.size() !== 4 || wc[2] !== e0 + 9 || wc[3] !== e0 + 11)
         $display("FAIL stall_writes: got n=%0d c2=%0d c3=%0d want 4 9 11", wa.size(), wc[2] - e0, wc[3] - e0);
      else pass_cnt++;
      total++;
   endtask

   task automatic test_reset_mid();
      rst_n = 1'b0;
      @(posedge clk); #1;
      release_reset();
      repeat (3) begin @(posedge clk); #1; end
      if ({ram_we, ram_addr} !== {1'b1, 10'd1}) $display("FAIL mid_write1: got we=%b a=%0d want we=1 a=1", ram_we, ram_addr); else pass_cnt++;
      total++;
      rst_n = 1'b0; #1;
      if ({rom_addr, ram_we, ram_addr, ram_wdata, cpu_hold, busy, done, csum_ok} !== {53'd0, 4'b1000})
         $display("FAIL mid_abort: got %0h want %0h", {rom_addr, ram_we, ram_addr, ram_wdata, cpu_hold, busy, done, csum_ok}, {53'd0, 4'b1000});
      else pass_cnt++;
      total++;
      clear_log();
      release_reset();
      wait_done(n);
      if (n !== 8 || wa.size() !== 4 || wa[0] !== 0 || wa[3] !== 3)
         $display("FAIL mid_recopy: got lat=%0d n=%0d want lat=8 n=4 a0=0 a3=3", n, wa.size());
      else pass_cnt++;
      total++;
   endtask

   task automatic test_restart();
      clear_log();
      pulse_start();
      if ({cpu_hold, busy, done} !== 3'b110) $display("FAIL restart_entry: got %b want 110", {cpu_hold, busy, done}); else pass_cnt++;
      total++;
      repeat (2) begin @(posedge clk); #1; end
      start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      wait_done(n);
      if (n !== 8) $display("FAIL restart_latency: got %0d want 8", n); else pass_cnt++;
      total++;
      repeat (4) begin @(posedge clk); #1; end
      if ({done, busy, cpu_hold} !== 3'b100 || wa.size() !== 4)
         $display("FAIL restart_ignored: got dbh=%b writes=%0d want 100 4", {done, busy, cpu_hold}, wa.size());
      else pass_cnt++;
      total++;
   endtask

   task automatic test_checksum();
      rom0 = 32'd1;
`ifdef BOOT_CHECKSUM_EN
      expected_sum = 32'd10;
      pulse_start();
      wait_done(n);
      if ({done, csum_ok, cpu_hold} !== 3'b110) $display("FAIL csum_match: got dok_h=%b want 110", {done, csum_ok, cpu_hold}); else pass_cnt++;
      total++;
      expected_sum = 32'd11;
      pulse_start();
      if (csum_ok !== 1'b0) $display("FAIL csum_clear: got %b want 0", csum_ok); else pass_cnt++;
      total++;
      wait_done(n);
      if ({done, csum_ok, cpu_hold} !== 3'b101) $display("FAIL csum_miss: got dok_h=%b want 101", {done, csum_ok, cpu_hold}); else pass_cnt++;
      total++;
`else
      expected_sum = 32'd11;
      pulse_start();
      if (csum_ok !== 1'b0) $display("FAIL csum_clear: got %b want 0", csum_ok); else pass_cnt++;
      total++;
      wait_done(n);
      if ({done, csum_ok, cpu_hold} !== 3'b110) $display("FAIL csum_follows_done: got dok_h=%b want 110", {done, csum_ok, cpu_hold}); else pass_cnt++;
      total++;
`endif
   endtask

   initial begin
      test_reset();
      test_auto_copy();
      test_stall();
      test_reset_mid();
      test_restart();
      test_checksum();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
